// File: rtl/lsu_byte_seq_if.sv
// lsu_byte_seq_if: request, response and byte-memory signals of the
// load/store byte sequencer, bundled as one interface.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. The requester holds req_valid and the req_*
// fields stable until that edge. rsp_valid is a one-cycle pulse and has no
// backpressure. mem_rdata is combinational from mem_addr.
//
// Modports:
//   slave  - the sequencer (drives req_ready, rsp_*, busy, mem_* strobes)
//   master - the requester plus memory (drives req_*, mem_rdata)
interface lsu_byte_seq_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq: accepts one RISC-V load/store (decoded by funct3) at a time
// and sequences it over an 8-bit memory port, one byte per cycle,
// little-endian. Loads return a sign- or zero-extended 32-bit result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        lsu_byte_seq_if.slave: req_*, rsp_*, busy, mem_*
//   dbg_state  current FSM state (0 IDLE, 1 XFER, 2 RESP)
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// halfword/word accesses are answered with an error response and never
// touch memory. When undefined they are performed byte by byte with wrap.
module lsu_byte_seq #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_byte_seq_if.slave       bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        idx_q;
    logic [31:0]       asm_q;
    logic              err_q;
    logic [31:0]       hold_rdata_q;
    logic              hold_err_q;

    logic              req_legal;
    logic              req_trap;
    logic              req_ok;
    logic [1:0]        last_idx;
    logic [31:0]       load_result;

    // Request decode. Stores only exist for byte/half/word (funct3[2]=0).
    always_comb begin
        req_legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !bus.req_write;
            default:                req_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        req_trap = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   req_trap = bus.req_addr[0];
            2'b10:   req_trap = (bus.req_addr[1:0] != 2'b00);
            default: req_trap = 1'b0;
        endcase
    end
`else
    assign req_trap = 1'b0;
`endif

    assign req_ok = req_legal && !req_trap;

    // Index of the final byte: 0, 1 or 3 for byte, half, word.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Extension of the assembled bytes; stores and errors report zero.
    always_comb begin
        load_result = 32'd0;
        if (!err_q && !wr_q) begin
            case (f3_q)
                3'b000:  load_result = {{24{asm_q[7]}}, asm_q[7:0]};
                3'b001:  load_result = {{16{asm_q[15]}}, asm_q[15:0]};
                3'b010:  load_result = asm_q;
                3'b100:  load_result = {24'd0, asm_q[7:0]};
                3'b101:  load_result = {16'd0, asm_q[15:0]};
                default: load_result = 32'd0;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = req_ok ? S_XFER : S_RESP;
            S_XFER:  if (idx_q == last_idx) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: request latch, byte index, load assembly, and the
    // response values that persist after the RESP pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q         <= 1'b0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            idx_q        <= 2'd0;
            asm_q        <= 32'd0;
            err_q        <= 1'b0;
            hold_rdata_q <= 32'd0;
            hold_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        idx_q   <= 2'd0;
                        asm_q   <= 32'd0;
                        err_q   <= !req_ok;
                    end
                end
                S_XFER: begin
                    idx_q <= idx_q + 2'd1;
                    if (!wr_q) asm_q[{idx_q, 3'b000} +: 8] <= bus.mem_rdata;
                end
                S_RESP: begin
                    hold_rdata_q <= load_result;
                    hold_err_q   <= err_q;
                end
                default: ;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.busy      = (state_q != S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_rdata = hold_rdata_q;
        bus.rsp_err   = hold_err_q;
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = 8'd0;
        if (state_q == S_RESP) begin
            bus.rsp_rdata = load_result;
            bus.rsp_err   = err_q;
        end
        if (state_q == S_XFER) begin
            // Address arithmetic is ADDR_W wide, so it wraps naturally.
            bus.mem_addr = addr_q + ADDR_W'(idx_q);
            bus.mem_re   = !wr_q;
            bus.mem_we   = wr_q;
            if (wr_q) bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        end
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq: directed bench for lsu_byte_seq. A transaction-level
// model turns each accepted request into the list of per-cycle outputs it
// must produce; one compare step checks every cycle against that list.
module tb_lsu_byte_seq;
    localparam int W = 53;  // {ready, re, we, addr[8], wdata[8], rv, err, rdata[32]}

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;

    lsu_byte_seq_if #(.ADDR_W(8)) bus ();

    lsu_byte_seq #(.ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // byte memory attached to the DUT, plus a bench-side preload path
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    int         we_cnt, re_cnt;

    assign bus.mem_rdata = mem[bus.mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        we_cnt = 0;
        re_cnt = 0;
    end

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus.mem_re) re_cnt <= re_cnt + 1;
    end

    // scoreboard / model state
    logic [W-1:0] exp_q[$];
    logic [7:0]   ref_mem [256];
    logic [31:0]  held_rd;
    logic         held_err;
    int           cyc, acc_n, acc_edge, rsp_n, rsp_edge;
    logic [31:0]  got_rd;
    logic         got_err;
    int           tests, fails;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ent(input bit rdy, input bit re, input bit we,
                                          input logic [7:0] a, input logic [7:0] wd,
                                          input bit rv, input bit err, input logic [31:0] rd);
        return {rdy, re, we, a, wd, rv, err, rd};
    endfunction

    // Model: expand an accepted request into its full cycle-by-cycle trace.
    task automatic model_accept(input bit wr, input logic [2:0] f3,
                                input logic [7:0] a, input logic [31:0] wd);
        bit          legal, trap;
        int          n;
        logic [31:0] raw, v;
        logic [7:0]  ba;
        legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
        if (!legal || trap) begin
            exp_q.push_back(ent(0, 0, 0, 8'd0, 8'd0, 1, 1, 32'd0));
        end else begin
            raw = 32'd0;
            for (int i = 0; i < n; i++) begin
                ba = a + 8'(i);
                if (wr) exp_q.push_back(ent(0, 0, 1, ba, wd[8*i +: 8], 0, 0, 32'd0));
                else begin
                    exp_q.push_back(ent(0, 1, 0, ba, 8'd0, 0, 0, 32'd0));
                    raw[8*i +: 8] = ref_mem[ba];
                end
            end
            case (f3)
                3'b000:  v = 32'($signed(raw[7:0]));
                3'b001:  v = 32'($signed(raw[15:0]));
                3'b100:  v = 32'(raw[7:0]);
                3'b101:  v = 32'(raw[15:0]);
                default: v = raw;
            endcase
            exp_q.push_back(ent(0, 0, 0, 8'd0, 8'd0, 1, 0, wr ? 32'd0 : v));
        end
        exp_q.push_back(ent(1, 0, 0, 8'd0, 8'd0, 0, 0, 32'd0));  // ready-again cycle
    endtask

    // One cycle of the compare process, run on the falling edge.
    task automatic model_compare();
        logic [W-1:0] e;
        logic [53:0]  exp_v, act_v;
        e = ent(1, 0, 0, 8'd0, 8'd0, 0, 0, 32'd0);
        if (!rst_n) begin
            exp_q.delete();
            held_rd  = 32'd0;
            held_err = 1'b0;
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
        if (e[33]) begin
            held_rd  = e[31:0];
            held_err = e[32];
        end
        if (e[50]) ref_mem[e[49:42]] = e[41:34];
        exp_v = {e[52], !e[52], e[51], e[50], e[49:42], e[41:34], e[33], held_err, held_rd};
        act_v = {bus.req_ready, bus.busy, bus.mem_re, bus.mem_we, bus.mem_addr,
                 bus.mem_wdata, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
        chk("cycle{rdy,busy,re,we,addr,wd,rv,err,rdata}", 64'(act_v), 64'(exp_v));
        if (bus.rsp_valid) begin
            got_rd   = bus.rsp_rdata;
            got_err  = bus.rsp_err;
            rsp_edge = cyc + 1;  // cycles numbered by the edge that closes them
            rsp_n++;
        end
    endtask

    // driver tasks
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic send(input bit wr, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input bit hold);
        int start;
        start          = acc_n;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        for (int i = 0; i < 20 && acc_n == start; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept_seen", 64'(acc_n != start), 64'd1);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("done_in_budget", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    int we0, re0, rsp0, a1;

    initial begin
        tests = 0; fails = 0; cyc = 0; acc_n = 0; rsp_n = 0;
        acc_edge = 0; rsp_edge = 0; got_rd = 0; got_err = 0;
        held_rd = 0; held_err = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        rst_n = 1'b0;
        pre_we = 1'b0; pre_addr = 8'd0; pre_data = 8'd0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 8'd0; bus.req_wdata = 32'd0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
                if (rst_n) begin
                    if (pre_we) ref_mem[pre_addr] = pre_data;
                    if (bus.req_valid && exp_q.size() == 0) begin
                        acc_n++;
                        acc_edge = cyc;
                        model_accept(bus.req_write, bus.req_funct3, bus.req_addr, bus.req_wdata);
                    end
                end
                @(negedge clk);
                model_compare();
            end
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rdata", 64'(bus.rsp_rdata), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // lw at 0x10
        preload(8'h10, 8'h78); preload(8'h11, 8'h56);
        preload(8'h12, 8'h34); preload(8'h13, 8'h12);
        re0 = re_cnt;
        send(0, 3'b010, 8'h10, 32'd0, 0);
        wait_done();
        chk("lw_data", 64'(got_rd), 64'h12345678);
        chk("lw_err", 64'(got_err), 64'd0);
        chk("lw_latency", 64'(rsp_edge - acc_edge), 64'd5);
        chk("lw_reads", 64'(re_cnt - re0), 64'd4);

        // byte and halfword extension
        preload(8'h20, 8'h80);
        send(0, 3'b000, 8'h20, 32'd0, 0); wait_done();
        chk("lb_data", 64'(got_rd), 64'hFFFFFF80);
        send(0, 3'b100, 8'h20, 32'd0, 0); wait_done();
        chk("lbu_data", 64'(got_rd), 64'h00000080);
        preload(8'h20, 8'h01); preload(8'h21, 8'h80);
        send(0, 3'b001, 8'h20, 32'd0, 0); wait_done();
        chk("lh_data", 64'(got_rd), 64'hFFFF8001);
        send(0, 3'b101, 8'h20, 32'd0, 0); wait_done();
        chk("lhu_data", 64'(got_rd), 64'h00008001);

        // sw with address wrap
        we0 = we_cnt;
        send(1, 3'b010, 8'hFE, 32'hDEADBEEF, 0); wait_done();
`ifdef LSU_MISALIGN_TRAP_EN
        chk("sw_wrap_err", 64'(got_err), 64'd1);
        chk("sw_wrap_latency", 64'(rsp_edge - acc_edge), 64'd1);
        chk("sw_wrap_writes", 64'(we_cnt - we0), 64'd0);
`else
        chk("sw_wrap_err", 64'(got_err), 64'd0);
        chk("sw_wrap_rdata", 64'(got_rd), 64'd0);
        chk("sw_wrap_writes", 64'(we_cnt - we0), 64'd4);
        chk("sw_wrap_memFE", 64'(mem[8'hFE]), 64'hEF);
        chk("sw_wrap_memFF", 64'(mem[8'hFF]), 64'hBE);
        chk("sw_wrap_mem00", 64'(mem[8'h00]), 64'hAD);
        chk("sw_wrap_mem01", 64'(mem[8'h01]), 64'hDE);
`endif

        // illegal funct3: load 011, store 100
        we0 = we_cnt; re0 = re_cnt;
        send(0, 3'b011, 8'h10, 32'd0, 0); wait_done();
        chk("ill_ld_err", 64'(got_err), 64'd1);
        chk("ill_ld_latency", 64'(rsp_edge - acc_edge), 64'd1);
        send(1, 3'b100, 8'h10, 32'h55, 0); wait_done();
        chk("ill_st_err", 64'(got_err), 64'd1);
        chk("ill_st_rdata", 64'(got_rd), 64'd0);
        chk("ill_mem_strobes", 64'((we_cnt - we0) + (re_cnt - re0)), 64'd0);

        // reset in the middle of a store
        preload(8'h42, 8'hAA); preload(8'h43, 8'hBB);
        rsp0 = rsp_n;
        send(1, 3'b010, 8'h40, 32'h11223344, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_rsp", 64'(rsp_n - rsp0), 64'd0);
        chk("rst_mem40", 64'(mem[8'h40]), 64'h44);
        chk("rst_mem41", 64'(mem[8'h41]), 64'h33);
        chk("rst_mem42", 64'(mem[8'h42]), 64'hAA);
        send(0, 3'b010, 8'h40, 32'd0, 0); wait_done();
        chk("rst_lw_data", 64'(got_rd), 64'hBBAA3344);

        // back-to-back: sb then lb with req_valid held
        send(1, 3'b000, 8'h50, 32'h000000C3, 1);
        a1 = acc_edge;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        send(0, 3'b000, 8'h50, 32'd0, 0);
        chk("b2b_accept_gap", 64'(acc_edge - a1), 64'd3);
        wait_done();
        chk("b2b_lb_data", 64'(got_rd), 64'hFFFFFFC3);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
